// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART framed command parser driving an 8-bit register bus
module uart_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CLKS = 100000,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter logic [7:0]  RESP_SYNC    = 8'h5A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_done,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       frame_err
);

  localparam int unsigned CW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

  typedef enum logic [3:0] {
    ST_HUNT, ST_CMD, ST_ADDR, ST_DATA, ST_CHK,
    ST_EXEC_W, ST_EXEC_R, ST_RD_WAIT, ST_RESP, ST_RESP2
  } state_t;

  state_t        state_q;
  logic          rx_done_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [7:0]    cmd_q, addr_q, data_q, resp_q;
  logic [7:0]    tx_data_q, reg_addr_q, reg_wdata_q;
  logic          tx_valid_q, reg_we_q, reg_re_q, frame_err_q;
  logic          rx_stb;
  logic          cmd_ok;
  logic [7:0]    chk_exp;

  // Rising edge of rx_done marks one received byte regardless of how long done stays high
  assign rx_stb  = rx_done & ~rx_done_q;
  // Idle-cycle count after this cycle; the frame is abandoned when it reaches the limit
  assign cnt_d   = cnt_q + 1'b1;
  assign cmd_ok  = (cmd_q == CMD_WR) || (cmd_q == CMD_RD);
  assign chk_exp = (cmd_q == CMD_WR) ? (cmd_q ^ addr_q ^ data_q) : (cmd_q ^ addr_q);

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign frame_err = frame_err_q;

  // Frame parser, bus sequencer and response handshake with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_HUNT;
      rx_done_q   <= 1'b0;
      cnt_q       <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      resp_q      <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_done_q   <= rx_done;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      frame_err_q <= 1'b0;
      unique case (state_q)
        ST_HUNT: begin
          if (rx_stb && (rx_byte == SYNC_BYTE)) begin
            state_q <= ST_CMD;
            cnt_q   <= '0;
          end
        end
        ST_CMD, ST_ADDR, ST_DATA, ST_CHK: begin
          if (rx_stb) begin
            // A byte arriving on the limit cycle is still accepted
            cnt_q <= '0;
            case (state_q)
              ST_CMD: begin
                cmd_q   <= rx_byte;
                state_q <= ST_ADDR;
              end
              ST_ADDR: begin
                addr_q  <= rx_byte;
                state_q <= (cmd_q == CMD_WR) ? ST_DATA : ST_CHK;
              end
              ST_DATA: begin
                data_q  <= rx_byte;
                state_q <= ST_CHK;
              end
              default: begin
                if (!cmd_ok || (rx_byte != chk_exp)) begin
                  resp_q      <= NAK;
                  frame_err_q <= 1'b1;
                  tx_valid_q  <= 1'b1;
                  tx_data_q   <= RESP_SYNC;
                  state_q     <= ST_RESP;
                end else if (cmd_q == CMD_WR) begin
                  reg_we_q    <= 1'b1;
                  reg_addr_q  <= addr_q;
                  reg_wdata_q <= data_q;
                  state_q     <= ST_EXEC_W;
                end else begin
                  reg_re_q    <= 1'b1;
                  reg_addr_q  <= addr_q;
                  state_q     <= ST_EXEC_R;
                end
              end
            endcase
          end else if (cnt_d == TO_LAST) begin
            state_q     <= ST_HUNT;
            frame_err_q <= 1'b1;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_EXEC_W: begin
          resp_q     <= ACK;
          tx_valid_q <= 1'b1;
          tx_data_q  <= RESP_SYNC;
          state_q    <= ST_RESP;
        end
        ST_EXEC_R: begin
          state_q <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          resp_q     <= reg_rdata;
          tx_valid_q <= 1'b1;
          tx_data_q  <= RESP_SYNC;
          state_q    <= ST_RESP;
        end
        ST_RESP: begin
          if (tx_ready) begin
            tx_data_q <= resp_q;
            state_q   <= ST_RESP2;
          end
        end
        ST_RESP2: begin
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            state_q    <= ST_HUNT;
          end
        end
        default: state_q <= ST_HUNT;
      endcase
    end
  end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Command controller between the UART receive/transmit datapaths and an 8-bit internal register bus.
- Takes bytes from the UART receiver's done/byte outputs, parses framed write/read commands and verifies the checksum.
- Drives the register bus and sequences a two-byte response into a UART transmitter through a valid/ready handshake.
- One controller per UART link; it is the only master of its register bus.

Parameters:
- TIMEOUT_CLKS, 100000: maximum clk cycles allowed between bytes inside a frame before the frame is abandoned.
- SYNC_BYTE, 8'hA5: start-of-frame byte.
- RESP_SYNC, 8'h5A: first byte of every response.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- rx_byte  input  8  received byte from the UART receiver
- rx_done  input  1  level from the UART receiver, high for one or more cycles per byte
- tx_data  output  8  byte to transmit
- tx_valid  output  1  tx_data is valid
- tx_ready  input  1  transmitter accepts tx_data this cycle
- reg_addr  output  8  register address
- reg_wdata  output  8  write data
- reg_we  output  1  one-cycle write strobe
- reg_re  output  1  one-cycle read strobe
- reg_rdata  input  8  read data, valid exactly 1 cycle after reg_re
- frame_err  output  1  one-cycle pulse on checksum error, unknown CMD or timeout

Behaviour:
- Reset: clk is the only clock; rst is asynchronous, active-low.
  - State = HUNT.
  - All outputs 0: tx_data, tx_valid, reg_addr, reg_wdata, reg_we, reg_re, frame_err.
  - Edge-detect register = 0; timeout counter = 0.
- Byte strobe: rx_stb = rx_done & ~rx_done_q, with rx_done_q registered every cycle. Exactly one strobe per received byte, however long rx_done stays high. rx_byte is sampled on the rx_stb cycle.
- Frame format: SYNC_BYTE, CMD, ADDR, [DATA if CMD=8'h01], CHK.
  - CHK = CMD ^ ADDR ^ DATA for writes; CMD ^ ADDR for reads.
  - CMD 8'h01 = write, 8'h02 = read.
- State transitions:
  - HUNT: on rx_stb with SYNC_BYTE -> CMD; any other byte is ignored silently.
  - CMD: on rx_stb, latch CMD -> ADDR. Unknown CMD values are latched and rejected at CHK.
  - ADDR: on rx_stb, latch ADDR -> DATA if CMD=01, else -> CHK.
  - DATA: on rx_stb, latch DATA -> CHK.
  - CHK: on rx_stb, compare the received byte with the checksum.
    - Mismatch or unknown CMD -> RESP with resp=8'h15 (NAK); frame_err pulses in the cycle after the strobe.
    - Match with write -> EXEC_W; match with read -> EXEC_R.
  - EXEC_W: reg_we=1, reg_addr, reg_wdata valid for exactly 1 cycle; resp=8'h06 (ACK) -> RESP.
  - EXEC_R: reg_re=1 for 1 cycle -> RD_WAIT.
  - RD_WAIT: capture reg_rdata as resp (1 cycle) -> RESP.
  - RESP: tx_valid=1, tx_data=RESP_SYNC. Hold both stable until tx_ready=1, then -> RESP2.
  - RESP2: tx_valid=1, tx_data=resp. On tx_ready -> HUNT with tx_valid=0 the next cycle.
- Handshake: a transfer occurs on any cycle where tx_valid & tx_ready. tx_data must not change while tx_valid is high and unaccepted. tx_ready may be high permanently, giving back-to-back transfers.
- Timeout (states CMD, ADDR, DATA, CHK only):
  - The counter clears on entry and on every rx_stb, and increments otherwise.
  - When it reaches TIMEOUT_CLKS-1 with no strobe: -> HUNT, frame_err pulse, no response sent.
  - A strobe in the same cycle as the limit wins: the byte is accepted and the counter clears.
- Bytes during EXEC/RD_WAIT/RESP/RESP2 are discarded; they are not buffered.
  - A SYNC_BYTE arriving during a response does not start a frame.
  - Parsing restarts only after return to HUNT.
- Latency:
  - Write: CHK strobe +1 cycle reg_we; +2 cycles tx_valid.
  - Read: CHK strobe +1 reg_re; +2 RD_WAIT; +3 tx_valid.
- Reset mid-operation: immediate return to reset values. Any partial frame is lost and any pending tx_valid drops asynchronously.

Test Plan:
- Write: bytes A5 01 10 3C 2D, tx_ready=1 -> one reg_we pulse with addr=10, wdata=3C; tx sequence 5A, 06; frame_err never high.
- Read: bytes A5 02 20 22, reg_rdata=99 on the cycle after reg_re -> one reg_re pulse with addr=20; tx sequence 5A, 99.
- Bad checksum: A5 01 10 3C 00 -> no reg_we; one frame_err pulse; tx 5A, 15. Unknown CMD A5 07 00 07 -> same NAK with no bus access.
- Timeout with TIMEOUT_CLKS=50: A5 01 then silence 60 cycles -> frame_err on cycle 50 after the last strobe, back in HUNT, no tx. A following full write frame is processed normally.
- Backpressure and stretched done: rx_done held 8 cycles per byte -> single strobe each. tx_ready low 20 cycles during RESP -> tx_data stays 5A with tx_valid stable; bytes sent while stalled are discarded.
- Async reset asserted during RESP2 -> tx_valid=0 immediately. After release, leading garbage 00 FF then a valid frame -> correct response.
